// File: rtl/borb_ibus_pkg.sv
// Shared types for the ibus fetch responder: queued command record, FSM states,
// and the fetch address fault check.
package borb_ibus_pkg;

  localparam int CMD_ADDR_W = 32;
  localparam int CMD_ID_W   = 16;

  typedef struct packed {
    logic [CMD_ADDR_W-1:0] address;
    logic [CMD_ID_W-1:0]   id;
  } ibus_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READ,
    ST_RESP
  } fsm_state_t;

  // Widened to 64 bits so base + 8*words cannot wrap for any supported address width.
  function automatic logic addr_fault(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input logic [63:0] words);
    logic [63:0] limit;
    limit = base + (words << 3);
    return (addr[2:0] != 3'b000) || (addr < base) || (addr >= limit);
  endfunction

endpackage

// File: rtl/ibus_cmd_fifo.sv
// Outstanding fetch command queue. Pointers carry an extra MSB to tell full from empty;
// push when full and pop when empty are ignored.
module ibus_cmd_fifo
  import borb_ibus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      clear,
  input  logic      push,
  input  ibus_cmd_t push_data,
  input  logic      pop,
  output ibus_cmd_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  ibus_cmd_t        storage [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = storage[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) storage[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/ibus_fetch_responder.sv
// Answers CPU instruction-bus fetches in order from a single-port synchronous memory,
// with a fixed wait before each read and bus errors for misaligned/out-of-range fetches.
module ibus_fetch_responder
  import borb_ibus_pkg::*;
#(
  parameter int               ADDR_W    = 32,
  parameter int               DATA_W    = 64,
  parameter int               ID_W      = 16,
  parameter int               DEPTH     = 4,
  parameter int               LATENCY   = 2,
  parameter logic [ADDR_W-1:0] MEM_BASE = 32'h8000_0000,
  parameter int               MEM_WORDS = 1024
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         ibus_cmd_valid,
  output logic                         ibus_cmd_ready,
  input  logic [ADDR_W-1:0]            ibus_cmd_address,
  input  logic [ID_W-1:0]              ibus_cmd_id,
  output logic                         ibus_rsp_valid,
  output logic [DATA_W-1:0]            ibus_rsp_data,
  output logic [ID_W-1:0]              ibus_rsp_id,
  output logic                         ibus_rsp_error,
  input  logic                         flush,
  output logic                         mem_rd_en,
  output logic [$clog2(MEM_WORDS)-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0]            mem_rd_data
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;

  // Handshake: a command is taken on a cycle where ibus_cmd_valid && ibus_cmd_ready;
  // responses are single-cycle pulses the CPU must consume, so there is no rsp ready.
  fsm_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ibus_cmd_t        push_cmd, head;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic             head_fault;
  logic [IDX_W-1:0] head_idx;

  logic [ID_W-1:0]   cur_id;
  logic              cur_fault;
  logic [IDX_W-1:0]  cur_idx;
  logic              rsp_fire;
  logic [DATA_W-1:0] rsp_word;
  logic [DATA_W-1:0] held_data;
  logic [ID_W-1:0]   held_id;
  logic              held_error;

  assign push_cmd       = '{address: ibus_cmd_address, id: ibus_cmd_id};
  assign ibus_cmd_ready = !fifo_full && !flush;

  ibus_cmd_fifo #(.DEPTH(DEPTH)) u_cmd_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (flush),
    .push      (ibus_cmd_valid && ibus_cmd_ready),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_fault = addr_fault(64'(head.address), 64'(MEM_BASE), 64'(MEM_WORDS));
  assign head_idx   = IDX_W'((head.address - MEM_BASE) >> 3);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The head is popped on leaving IDLE or RESP so back-to-back fetches need no idle cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cnt_d    = '0;
          state_d  = (LATENCY > 0) ? ST_WAIT : ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_READ;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_READ: state_d = ST_RESP;
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      fifo_pop = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_id    <= '0;
      cur_fault <= 1'b0;
      cur_idx   <= '0;
    end else if (fifo_pop) begin
      cur_id    <= head.id;
      cur_fault <= head_fault;
      cur_idx   <= head_idx;
    end
  end

  assign mem_rd_en   = (state_q == ST_READ) && !cur_fault && !flush;
  assign mem_rd_addr = cur_idx;

  // Live memory data during the response cycle; last response held otherwise.
  assign rsp_fire       = (state_q == ST_RESP) && !flush;
  assign rsp_word       = cur_fault ? '0 : mem_rd_data;
  assign ibus_rsp_valid = rsp_fire;
  assign ibus_rsp_data  = rsp_fire ? rsp_word  : held_data;
  assign ibus_rsp_id    = rsp_fire ? cur_id    : held_id;
  assign ibus_rsp_error = rsp_fire ? cur_fault : held_error;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      held_data  <= '0;
      held_id    <= '0;
      held_error <= 1'b0;
    end else if (rsp_fire) begin
      held_data  <= rsp_word;
      held_id    <= cur_id;
      held_error <= cur_fault;
    end
  end

endmodule

// File: tb/tb_ibus_fetch_responder.sv
// Bench for ibus_fetch_responder: one instance at LATENCY=2 and one at LATENCY=0,
// each with a behavioural memory and an in-order response scoreboard.
module tb_ibus_fetch_responder;

  localparam int SB_W = 16 + 1 + 64;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // LATENCY=2 instance
  logic        a_cmd_valid = 1'b0, a_cmd_ready;
  logic [31:0] a_cmd_address = '0;
  logic [15:0] a_cmd_id = '0;
  logic        a_rsp_valid, a_rsp_error, a_mem_rd_en;
  logic [63:0] a_rsp_data, a_mem_rd_data;
  logic [15:0] a_rsp_id;
  logic [9:0]  a_mem_rd_addr;

  // LATENCY=0 instance
  logic        z_cmd_valid = 1'b0, z_cmd_ready;
  logic [31:0] z_cmd_address = '0;
  logic [15:0] z_cmd_id = '0;
  logic        z_rsp_valid, z_rsp_error, z_mem_rd_en;
  logic [63:0] z_rsp_data, z_mem_rd_data;
  logic [15:0] z_rsp_id;
  logic [9:0]  z_mem_rd_addr;

  ibus_fetch_responder #(.LATENCY(2)) u_dut_a (
    .clock(clock), .reset(reset),
    .ibus_cmd_valid(a_cmd_valid), .ibus_cmd_ready(a_cmd_ready),
    .ibus_cmd_address(a_cmd_address), .ibus_cmd_id(a_cmd_id),
    .ibus_rsp_valid(a_rsp_valid), .ibus_rsp_data(a_rsp_data),
    .ibus_rsp_id(a_rsp_id), .ibus_rsp_error(a_rsp_error),
    .flush(flush),
    .mem_rd_en(a_mem_rd_en), .mem_rd_addr(a_mem_rd_addr), .mem_rd_data(a_mem_rd_data)
  );

  ibus_fetch_responder #(.LATENCY(0)) u_dut_z (
    .clock(clock), .reset(reset),
    .ibus_cmd_valid(z_cmd_valid), .ibus_cmd_ready(z_cmd_ready),
    .ibus_cmd_address(z_cmd_address), .ibus_cmd_id(z_cmd_id),
    .ibus_rsp_valid(z_rsp_valid), .ibus_rsp_data(z_rsp_data),
    .ibus_rsp_id(z_rsp_id), .ibus_rsp_error(z_rsp_error),
    .flush(1'b0),
    .mem_rd_en(z_mem_rd_en), .mem_rd_addr(z_mem_rd_addr), .mem_rd_data(z_mem_rd_data)
  );

  function automatic logic [63:0] mem_word(input logic [9:0] idx);
    return {16'hC0DE, 6'b0, idx, 32'h1234_5678 ^ {22'b0, idx}};
  endfunction

  always @(posedge clock) begin
    if (a_mem_rd_en) a_mem_rd_data <= mem_word(a_mem_rd_addr);
    if (z_mem_rd_en) z_mem_rd_data <= mem_word(z_mem_rd_addr);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard and observation logs
  logic [SB_W-1:0] a_exp_q[$];
  logic [SB_W-1:0] z_exp_q[$];
  int a_rsp_log[$];
  int z_rsp_log[$];
  int a_rd_cnt = 0;
  int a_last_rd_cyc = -1;
  logic [9:0] a_last_rd_addr = '0;

  always @(negedge clock) begin
    if (a_mem_rd_en) begin
      a_rd_cnt++;
      a_last_rd_cyc  = cyc;
      a_last_rd_addr = a_mem_rd_addr;
    end
    if (a_rsp_valid) begin
      a_rsp_log.push_back(cyc);
      if (a_exp_q.size() == 0) check("a_rsp_unexpected", a_rsp_valid, 1'b0);
      else check("a_rsp", {a_rsp_id, a_rsp_error, a_rsp_data}, a_exp_q.pop_front());
    end
    if (z_rsp_valid) begin
      z_rsp_log.push_back(cyc);
      if (z_exp_q.size() == 0) check("z_rsp_unexpected", z_rsp_valid, 1'b0);
      else check("z_rsp", {z_rsp_id, z_rsp_error, z_rsp_data}, z_exp_q.pop_front());
    end
  end

  // Offers one command; acc is the cycle in which it was accepted (-2 on timeout).
  task automatic send(input bit z, input logic [31:0] addr, input logic [15:0] id,
                      input bit err, input logic [9:0] idx, output int acc);
    int budget;
    budget = 0;
    acc = -1;
    while (acc == -1) begin
      @(negedge clock);
      if ((z ? z_cmd_ready : a_cmd_ready) && !flush) begin
        if (z) begin z_cmd_valid = 1'b1; z_cmd_address = addr; z_cmd_id = id; end
        else   begin a_cmd_valid = 1'b1; a_cmd_address = addr; a_cmd_id = id; end
        @(posedge clock);
        #1;
        acc = cyc - 1;
        if (z) z_exp_q.push_back({id, err, err ? 64'h0 : mem_word(idx)});
        else   a_exp_q.push_back({id, err, err ? 64'h0 : mem_word(idx)});
        a_cmd_valid = 1'b0;
        z_cmd_valid = 1'b0;
      end else begin
        budget++;
        if (budget > 60) begin
          check("send_timeout", z ? z_cmd_ready : a_cmd_ready, 1'b1);
          acc = -2;
        end
      end
    end
  endtask

  task automatic wait_rsp(input bit z, input int n, input int budget, input string name);
    int k;
    k = 0;
    while ((z ? z_rsp_log.size() : a_rsp_log.size()) < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    @(negedge clock);
    check(name, (z ? z_rsp_log.size() : a_rsp_log.size()) >= n, 1'b1);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [15:0] id;
    bit          err;
    logic [9:0]  idx;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t0, base, rd_base, guard;
    int acc[6];

    vecs[0] = '{32'h8000_0000, 16'h0100, 1'b0, 10'd0};
    vecs[1] = '{32'h8000_1FF8, 16'h0101, 1'b0, 10'd1023};
    vecs[2] = '{32'h8000_0004, 16'h0102, 1'b1, 10'd0};
    vecs[3] = '{32'h7FFF_FFF8, 16'h0103, 1'b1, 10'd0};
    vecs[4] = '{32'h8000_2000, 16'h0104, 1'b1, 10'd0};
    vecs[5] = '{32'hFFFF_FFF8, 16'h0105, 1'b1, 10'd0};
    vecs[6] = '{32'h8000_0A48, 16'h0106, 1'b0, 10'd329};
    vecs[7] = '{32'h0000_0000, 16'h0107, 1'b1, 10'd0};

    // Reset state
    repeat (3) @(negedge clock);
    check("reset_ready", a_cmd_ready, 1'b1);
    check("reset_rsp_valid", a_rsp_valid, 1'b0);
    check("reset_rd_en", a_mem_rd_en, 1'b0);
    check("reset_rsp_data", a_rsp_data, 64'h0);
    check("reset_rsp_id", a_rsp_id, 16'h0);
    check("reset_rd_addr", a_mem_rd_addr, 10'h0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("post_reset_ready", a_cmd_ready, 1'b1);

    // Single fetch latency and address
    rd_base = a_rd_cnt;
    base = a_rsp_log.size();
    send(1'b0, 32'h8000_0010, 16'h0005, 1'b0, 10'd2, t);
    wait_rsp(1'b0, base + 1, 20, "single_rsp_seen");
    check("single_rsp_cycle", a_rsp_log[base], t + 5);
    check("single_rd_cycle", a_last_rd_cyc, t + 4);
    check("single_rd_addr", a_last_rd_addr, 10'd2);
    check("single_rd_count", a_rd_cnt - rd_base, 1);

    // Table of normal, boundary and faulting fetches
    rd_base = a_rd_cnt;
    base = a_rsp_log.size();
    foreach (vecs[i]) send(1'b0, vecs[i].addr, vecs[i].id, vecs[i].err, vecs[i].idx, t);
    wait_rsp(1'b0, base + 8, 80, "table_rsp_seen");
    check("table_rd_count", a_rd_cnt - rd_base, 3);

    // Faults only: never touch memory, normal latency and spacing
    rd_base = a_rd_cnt;
    base = a_rsp_log.size();
    send(1'b0, 32'h8000_0004, 16'h0E01, 1'b1, 10'd0, t);
    send(1'b0, 32'h7FFF_FFF8, 16'h0E02, 1'b1, 10'd0, t0);
    send(1'b0, 32'h8000_2000, 16'h0E03, 1'b1, 10'd0, t0);
    wait_rsp(1'b0, base + 3, 40, "fault_rsp_seen");
    check("fault_rd_count", a_rd_cnt - rd_base, 0);
    check("fault_first_cycle", a_rsp_log[base], t + 5);
    check("fault_spacing", a_rsp_log[base + 2] - a_rsp_log[base + 1], 4);

    // Burst of six into a four-deep queue
    base = a_rsp_log.size();
    for (int i = 0; i < 6; i++)
      send(1'b0, 32'h8000_0200 + 32'(8 * i), 16'(i + 1), 1'b0, 10'(64 + i), acc[i]);
    check("burst_first_five_back_to_back", acc[4] - acc[0], 4);
    check("burst_sixth_held_off", acc[5] - acc[0], 6);
    wait_rsp(1'b0, base + 6, 60, "burst_rsp_seen");
    check("burst_first_cycle", a_rsp_log[base], acc[0] + 5);
    for (int i = 1; i < 6; i++)
      check("burst_spacing", a_rsp_log[base + i] - a_rsp_log[base + i - 1], 4);

    // Flush with three queued and one waiting
    for (int i = 0; i < 5; i++)
      send(1'b0, 32'h8000_0100 + 32'(8 * i), 16'(16'h11 + i), 1'b0, 10'(32 + i), acc[i]);
    t0 = acc[0];
    guard = 0;
    while (cyc < t0 + 6 && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    flush = 1'b1;
    a_cmd_valid = 1'b1;
    a_cmd_address = 32'h8000_0000;
    a_cmd_id = 16'h0077;
    #1;
    check("flush_ready_low", a_cmd_ready, 1'b0);
    check("flush_rsp_valid", a_rsp_valid, 1'b0);
    check("flush_outstanding", a_exp_q.size(), 4);
    a_exp_q.delete();
    @(negedge clock);
    flush = 1'b0;
    a_cmd_valid = 1'b0;
    base = a_rsp_log.size();
    rd_base = a_rd_cnt;
    repeat (20) @(negedge clock);
    check("flush_no_rsp", a_rsp_log.size() - base, 0);
    check("flush_no_read", a_rd_cnt - rd_base, 0);
    send(1'b0, 32'h8000_0030, 16'h0009, 1'b0, 10'd6, t);
    wait_rsp(1'b0, base + 1, 20, "post_flush_rsp_seen");
    check("post_flush_cycle", a_rsp_log[base], t + 5);

    // Asynchronous reset during READ
    send(1'b0, 32'h8000_0040, 16'h0021, 1'b0, 10'd8, t);
    guard = 0;
    while (!a_mem_rd_en && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    check("reached_read", a_mem_rd_en, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_reset_rd_en", a_mem_rd_en, 1'b0);
    check("mid_reset_rsp_valid", a_rsp_valid, 1'b0);
    check("mid_reset_ready", a_cmd_ready, 1'b1);
    check("mid_reset_rsp_id", a_rsp_id, 16'h0);
    check("mid_reset_rsp_data", a_rsp_data, 64'h0);
    check("mid_reset_rsp_error", a_rsp_error, 1'b0);
    a_exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    base = a_rsp_log.size();
    repeat (15) @(negedge clock);
    check("post_reset_no_rsp", a_rsp_log.size() - base, 0);

    // LATENCY=0 back-to-back
    base = z_rsp_log.size();
    send(1'b1, 32'h8000_0018, 16'h000A, 1'b0, 10'd3, t);
    send(1'b1, 32'h8000_0020, 16'h000B, 1'b0, 10'd4, t0);
    check("lat0_back_to_back_accept", t0 - t, 1);
    wait_rsp(1'b1, base + 2, 20, "lat0_rsp_seen");
    check("lat0_first_cycle", z_rsp_log[base], t + 3);
    check("lat0_second_cycle", z_rsp_log[base + 1], t + 5);

    repeat (5) @(negedge clock);
    check("a_scoreboard_drained", a_exp_q.size(), 0);
    check("z_scoreboard_drained", z_exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
